dmem_responder: RTL and testbench

- Backing data-memory responder that sits on the memory side of the data cache's miss/write-back interface.
- Serves the cache's fixed-latency line reads and posted write-backs, one 32-bit word per transfer.
- Storage is a single-port word array. Write-backs are queued in a small posting buffer and drained into the array in idle cycles; reads always take priority.
- Reads forward from the posting buffer so that the newest data is always returned.

---
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Purpose: backing data memory behind the data cache, serving line reads and posted write-backs.
// Latency: read strobe in cycle N gives registered data valid in cycle N+1; write-backs drain in idle cycles.
// Backpressure: none; a write that arrives while the buffer is full and a read is active is dropped and flagged.
module dmem_responder #(
  parameter int ADDR_W     = 14,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   m_rd_address,
  input  logic                          mrden,
  input  logic [15:0]                   m_wr_address,
  input  logic                          mwren,
  input  logic [31:0]                   data2mem,
  output logic [31:0]                   data_in_mem,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);

  // Single-port word storage; never cleared by reset.
  logic [31:0] mem [2**ADDR_W];

  // Posting buffer state.
  logic [ADDR_W-1:0]     wb_addr_q [WBUF_DEPTH];
  logic [ADDR_W-1:0]     wb_addr_d [WBUF_DEPTH];
  logic [31:0]           wb_data_q [WBUF_DEPTH];
  logic [31:0]           wb_data_d [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] wb_vld_q, wb_vld_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           rdata_q, rdata_d;

  // Request decode.
  logic [ADDR_W-1:0] rd_word;
  logic [ADDR_W-1:0] wr_word;
  logic              buf_full;
  logic              push_en;
  logic              drop_en;
  logic              drain_en;
  logic              mem_we;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;
  logic              fwd_hit;
  logic [31:0]       fwd_data;

  // Byte-offset bits carry no information for word transfers.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{m_rd_address[1:0], m_wr_address[1:0]};

  assign rd_word = m_rd_address[ADDR_W+1:2];
  assign wr_word = m_wr_address[ADDR_W+1:2];

  // Arbitration: a read owns the array port; a full buffer can only absorb a write by draining.
  always_comb begin
    buf_full  = (cnt_q == FULL_CNT);
    drop_en   = mwren && mrden && buf_full;
    push_en   = mwren && !drop_en;
    drain_en  = !mrden && (cnt_q != '0);
    head_addr = wb_addr_q[rd_ptr_q];
    head_data = wb_data_q[rd_ptr_q];
    mem_we    = drain_en && rst;
  end

  // Newest matching buffer entry: walk oldest to newest so later hits override earlier ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = rd_ptr_q;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (wb_vld_q[idx] && (wb_addr_q[idx] == rd_word)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[idx];
      end
    end
  end

  // Read data source: same-cycle write, then newest buffered write, then the array.
  always_comb begin
    rdata_d = rdata_q;
    if (mrden) begin
      if (mwren && (wr_word == rd_word)) begin
        rdata_d = data2mem;
      end else if (fwd_hit) begin
        rdata_d = fwd_data;
      end else begin
        rdata_d = mem[rd_word];
      end
    end
  end

  // Buffer next-state: pop the head on drain, append at the tail on push (push wins a shared slot).
  always_comb begin
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_vld_d  = wb_vld_q;
    rd_ptr_d  = rd_ptr_q + PTR_W'(drain_en);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push_en);
    cnt_d     = cnt_q + CNT_W'(push_en) - CNT_W'(drain_en);
    ovf_d     = ovf_q || drop_en;
    if (drain_en) begin
      wb_vld_d[rd_ptr_q] = 1'b0;
    end
    if (push_en) begin
      wb_addr_d[wr_ptr_q] = wr_word;
      wb_data_d[wr_ptr_q] = data2mem;
      wb_vld_d[wr_ptr_q]  = 1'b1;
    end
  end

  // Control and buffer registers; reset discards every queued write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
      wb_vld_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_vld_q  <= wb_vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
    end
  end

  // Array write port: retire the buffer head when the port is free.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[head_addr] <= head_data;
    end
  end

  assign data_in_mem = rdata_q;
  assign wbuf_count  = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: directed checks of read forwarding, write posting, full/overflow boundary and async reset.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next one.
// Backpressure: not applicable; the responder never stalls.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] m_rd_address;
  logic        mrden;
  logic [15:0] m_wr_address;
  logic        mwren;
  logic [31:0] data2mem;
  logic [31:0] data_in_mem;
  logic [2:0]  wbuf_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.ADDR_W(14), .WBUF_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_rd_address (m_rd_address),
    .mrden        (mrden),
    .m_wr_address (m_wr_address),
    .mwren        (mwren),
    .data2mem     (data2mem),
    .data_in_mem  (data_in_mem),
    .wbuf_count   (wbuf_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mrden = 1'b0;
    mwren = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    m_wr_address = a;
    data2mem     = d;
    mwren        = 1'b1;
    step();
    mwren        = 1'b0;
  endtask

  // Write while a read is held active, so the write cannot drain.
  task automatic wr_rd(input logic [15:0] wa, input logic [31:0] d, input logic [15:0] ra);
    m_wr_address = wa;
    data2mem     = d;
    m_rd_address = ra;
    mwren        = 1'b1;
    mrden        = 1'b1;
    step();
    mwren        = 1'b0;
    mrden        = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    m_rd_address = a;
    mrden        = 1'b1;
    step();
    mrden        = 1'b0;
    chk(tag, data_in_mem, exp);
  endtask

  initial begin
    m_rd_address = '0;
    m_wr_address = '0;
    mrden        = 1'b0;
    mwren        = 1'b0;
    data2mem     = '0;

    // Power-on reset.
    #2 rst = 1'b0;
    #2;
    chk("reset_data", data_in_mem, 32'h0);
    chk("reset_count", {29'd0, wbuf_count}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Write, let it drain, read back from the array.
    wr(16'h0040, 32'hDEADBEEF);
    chk("wr_count1", {29'd0, wbuf_count}, 32'd1);
    idle(8);
    chk("drain_count0", {29'd0, wbuf_count}, 32'd0);
    rd_chk("rd_array_40", 16'h0040, 32'hDEADBEEF);
    chk("rd_count0", {29'd0, wbuf_count}, 32'd0);
    idle(2);
    chk("data_held", data_in_mem, 32'hDEADBEEF);

    // Two writes to one word; the read must see the newer one from the buffer.
    wr(16'h0010, 32'h11111111);
    wr(16'h0010, 32'h22222222);
    chk("two_wr_count", {29'd0, wbuf_count}, 32'd1);
    rd_chk("fwd_buf_newest", 16'h0010, 32'h22222222);
    idle(3);
    chk("fwd_drained", {29'd0, wbuf_count}, 32'd0);
    rd_chk("last_write_wins", 16'h0010, 32'h22222222);

    // Same-cycle forward onto a zero word.
    wr(16'h0020, 32'h00000000);
    idle(2);
    wr_rd(16'h0020, 32'hA5A5A5A5, 16'h0020);
    chk("same_cycle_fwd", data_in_mem, 32'hA5A5A5A5);
    chk("same_cycle_count", {29'd0, wbuf_count}, 32'd1);
    idle(2);
    rd_chk("same_cycle_array", 16'h0020, 32'hA5A5A5A5);

    // Fill the buffer under continuous reads, then push into a full buffer with no read.
    for (int i = 0; i < 4; i++) begin
      wr_rd(16'h0200 + 16'(4 * i), 32'h10000001 + 32'(i), 16'h0040);
      chk("fill_rd", data_in_mem, 32'hDEADBEEF);
    end
    chk("fill_count4", {29'd0, wbuf_count}, 32'd4);
    wr(16'h0210, 32'h10000005);
    chk("full_push_count", {29'd0, wbuf_count}, 32'd4);
    chk("full_push_ovf", {31'd0, overflow}, 32'd0);
    idle(5);
    chk("fill_drained", {29'd0, wbuf_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd_chk("fill_readback", 16'h0200 + 16'(4 * i), 32'h10000001 + 32'(i));
    end

    // Overflow: full buffer, write and read in the same cycle to different words.
    for (int i = 0; i < 4; i++) begin
      wr_rd(16'h0300 + 16'(4 * i), 32'h30000001 + 32'(i), 16'h0040);
    end
    wr_rd(16'h0010, 32'hBAD0BAD0, 16'h0040);
    chk("ovf_rd_wins", data_in_mem, 32'hDEADBEEF);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {29'd0, wbuf_count}, 32'd4);
    idle(5);
    rd_chk("ovf_dropped", 16'h0010, 32'h22222222);
    rd_chk("ovf_kept_head", 16'h0300, 32'h30000001);
    rd_chk("ovf_kept_tail", 16'h030C, 32'h30000004);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Queue three writes, then reset asynchronously between edges.
    wr_rd(16'h0040, 32'hCAFE0001, 16'h0010);
    chk("pre_rst_array", data_in_mem, 32'h22222222);
    wr_rd(16'h0010, 32'hCAFE0002, 16'h0010);
    wr_rd(16'h0020, 32'hCAFE0003, 16'h0010);
    chk("pre_rst_fwd", data_in_mem, 32'hCAFE0002);
    chk("pre_rst_count", {29'd0, wbuf_count}, 32'd3);
    rst = 1'b0;
    #1;
    chk("async_rst_count", {29'd0, wbuf_count}, 32'd0);
    chk("async_rst_data", data_in_mem, 32'h0);
    chk("async_rst_ovf", {31'd0, overflow}, 32'd0);
    #2 rst = 1'b1;
    step();
    idle(2);
    rd_chk("lost_wr_40", 16'h0040, 32'hDEADBEEF);
    rd_chk("lost_wr_10", 16'h0010, 32'h22222222);
    rd_chk("lost_wr_20", 16'h0020, 32'hA5A5A5A5);
    chk("post_rst_count", {29'd0, wbuf_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
